mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- Consumer end of the EX/MEM pipeline register, used in the MEM stage.
- Takes memRead/memWrite, width, sign and address/data from EX/MEM and runs a request/grant/response transaction on the data-memory port.
- Stalls the pipeline while the access is outstanding.
- Produces aligned, extended load data plus the Rd/write-enable for the MEM/WB register.

Parameters:
- ADDR_W, 32, data-memory address width.
- XLEN, 32, data width (fixed at 32; 4 byte lanes).

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- memRead  in  1  load request from EX/MEM.
- memWrite  in  1  store request from EX/MEM.
- WL  in  2  access width: 00 byte, 01 half, 10 word, 11 treated as word.
- extendSign  in  1  1 = sign-extend loads, 0 = zero-extend.
- AluOut  in  ADDR_W  effective byte address.
- storeData  in  32  store source value, right-justified.
- Rd  in  5  destination register.
- regesterW  in  1  register write enable.
- dmemReq  out  1  memory request, registered.
- dmemWe  out  1  1 = write.
- dmemAddr  out  ADDR_W  word-aligned address ({AluOut[ADDR_W-1:2],2'b00}).
- dmemBe  out  4  byte enables.
- dmemWdata  out  32  lane-replicated store data.
- dmemGnt  in  1  memory accepted request this cycle.
- dmemRvalid  in  1  read data valid.
- dmemRdata  in  32  read data.
- stall  out  1  hold IF..EX/MEM, combinational.
- loadData  out  32  aligned, extended load result.
- loadValid  out  1  one-cycle pulse, load complete.
- Rdo  out  5  Rd passthrough for MEM/WB.
- regesterWo  out  1  regesterW passthrough for MEM/WB.
- trap  out  1  misaligned-access pulse (only with MISALIGN_TRAP_EN; tied 0 otherwise).

Behaviour:
- FSM states: IDLE, REQ, WAIT, DONE.
- Reset: state IDLE. dmemReq, dmemWe, dmemAddr, dmemBe, dmemWdata, loadData, loadValid, trap all 0.
- Reset mid-transaction: abandons the access. A late dmemRvalid is ignored in IDLE.
- IDLE:
  - If memRead|memWrite, latch address/BE/wdata/WL/extendSign/offset, drive dmemReq=1 next cycle, go REQ.
  - stall = memRead|memWrite, combinational, so it asserts the same cycle the access arrives.
- REQ:
  - dmemReq held with stable outputs until dmemGnt.
  - On gnt, dmemReq drops next cycle.
  - Write: go DONE.
  - Read with dmemRvalid the same cycle as gnt: capture, go DONE.
  - Read otherwise: go WAIT.
- WAIT: on dmemRvalid, capture extracted data into loadData, go DONE.
- DONE:
  - stall=0; loadValid=1 only for reads; return to IDLE.
  - Inputs in the DONE cycle belong to the finished access and are ignored.
- stall = 1 in REQ and WAIT.
- Latency with zero-wait memory: store 3 cycles (IDLE→REQ→DONE); load 3 cycles with gnt+rvalid together, 4 cycles otherwise.
- memRead and memWrite both high: treated as write; loadValid not pulsed.
- Store lanes, off = AluOut[1:0]:
  - Byte: BE = 1<<off; wdata = {4{sd[7:0]}}.
  - Half: BE = off[1] ? 1100 : 0011; wdata = {2{sd[15:0]}}.
  - Word: BE = 1111.
- Load extract:
  - Byte = rdata[8*off+:8]; half = rdata[16*off[1]+:16].
  - Extend to 32 bits per the latched extendSign.
- Rdo and regesterWo are combinational passthroughs of Rd and regesterW.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - Half access with off[0]=1, or word access with off≠0, issues no request.
  - FSM goes IDLE→DONE; trap pulses 1 cycle in DONE; regesterWo forced 0 that cycle; loadValid stays 0.
- Undefined:
  - Low address bits are ignored (half uses off[1], word uses lane 0); trap tied 0.

Decomposition:
- Package mem_access_pkg: WL encodings (WL_BYTE, WL_HALF, WL_WORD), FSM state enum, lane-count constant.
- One combinational sub-module, lsu_lane_align: BE and wdata generation plus load extract/extend; shared by the store and load paths.

Test Plan:
- Store byte, AluOut=0x1003, storeData=0xAB, gnt on first REQ cycle → dmemAddr=0x1000, BE=1000, wdata=0xABABABAB, stall high exactly 2 cycles.
- Load half signed, AluOut=0x2002, rdata=0x8001_1234, rvalid 2 cycles after gnt → loadData=0xFFFF8001, loadValid one pulse, stall held through WAIT.
- Load byte unsigned, off=1, rdata=0x0000_F500, gnt+rvalid same cycle → loadData=0x000000F5, 3-cycle latency.
- gnt withheld 5 cycles → dmemReq, dmemAddr, dmemBe stable throughout; stall continuous.
- rst asserted in WAIT, then rvalid=1 → all outputs 0, state IDLE, no loadValid.
- With MISALIGN_TRAP_EN: word load at 0x3002 → no dmemReq, trap pulse, regesterWo=0. Without the macro: request issued to 0x3000 with BE=1111.

Source files
------------

// File: rtl/mem_access_pkg.sv
// mem_access_pkg: access-width encodings, MEM-stage FSM states and lane count
package mem_access_pkg;
   localparam logic [1:0] WL_BYTE = 2'b00;
   localparam logic [1:0] WL_HALF = 2'b01;
   localparam logic [1:0] WL_WORD = 2'b10;
   localparam int LANES = 4;
   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: store byte-enable/lane replication and load extract/extend
module lsu_lane_align
   import mem_access_pkg::*;
(
   input  logic [1:0]       wl_st,
   input  logic [1:0]       off_st,
   input  logic [31:0]      sd,
   output logic [LANES-1:0] be,
   output logic [31:0]      wdata,
   input  logic [1:0]       wl_ld,
   input  logic [1:0]       off_ld,
   input  logic             sext,
   input  logic [31:0]      rdata,
   output logic [31:0]      ldata
);
   logic [7:0]  b;
   logic [15:0] h;
   always_comb begin
      be    = wl_st == WL_BYTE ? 4'b0001 << off_st :
              wl_st == WL_HALF ? (off_st[1] ? 4'b1100 : 4'b0011) : 4'b1111;
      wdata = wl_st == WL_BYTE ? {4{sd[7:0]}} :
              wl_st == WL_HALF ? {2{sd[15:0]}} : sd;
      b     = rdata[{off_ld, 3'b000} +: 8];
      h     = rdata[{off_ld[1], 4'b0000} +: 16];
      ldata = wl_ld == WL_BYTE ? {{24{sext & b[7]}}, b} :
              wl_ld == WL_HALF ? {{16{sext & h[15]}}, h} : rdata;
   end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store engine on a req/gnt/rvalid port; MISALIGN_TRAP_EN enables misaligned-access traps
module mem_access_unit
   import mem_access_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int XLEN   = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              memRead,
   input  logic              memWrite,
   input  logic [1:0]        WL,
   input  logic              extendSign,
   input  logic [ADDR_W-1:0] AluOut,
   input  logic [XLEN-1:0]   storeData,
   input  logic [4:0]        Rd,
   input  logic              regesterW,
   output logic              dmemReq,
   output logic              dmemWe,
   output logic [ADDR_W-1:0] dmemAddr,
   output logic [LANES-1:0]  dmemBe,
   output logic [XLEN-1:0]   dmemWdata,
   input  logic              dmemGnt,
   input  logic              dmemRvalid,
   input  logic [XLEN-1:0]   dmemRdata,
   output logic              stall,
   output logic [XLEN-1:0]   loadData,
   output logic              loadValid,
   output logic [4:0]        Rdo,
   output logic              regesterWo,
   output logic              trap
);
   state_t           state;
   logic [1:0]       wl_q, off_q;
   logic             sext_q, go, misalign;
   logic [LANES-1:0] be_n;
   logic [XLEN-1:0]  wdata_n, ldata;
   assign go = memRead | memWrite;
`ifdef MISALIGN_TRAP_EN
   assign misalign = (WL == WL_HALF && AluOut[0]) || (WL[1] && AluOut[1:0] != 2'b00);
`else
   assign misalign = 1'b0;
`endif
   assign stall      = state == IDLE ? go : (state == REQ || state == WAIT);
   assign Rdo        = Rd;
   assign regesterWo = regesterW & ~trap;
   lsu_lane_align u_align (
      .wl_st  (WL),
      .off_st (AluOut[1:0]),
      .sd     (storeData),
      .be     (be_n),
      .wdata  (wdata_n),
      .wl_ld  (wl_q),
      .off_ld (off_q),
      .sext   (sext_q),
      .rdata  (dmemRdata),
      .ldata  (ldata)
   );
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         dmemReq   <= 1'b0;
         dmemWe    <= 1'b0;
         dmemAddr  <= '0;
         dmemBe    <= '0;
         dmemWdata <= '0;
         loadData  <= '0;
         loadValid <= 1'b0;
         trap      <= 1'b0;
         wl_q      <= '0;
         off_q     <= '0;
         sext_q    <= 1'b0;
      end else begin
         loadValid <= 1'b0;
         trap      <= 1'b0;
         case (state)
            IDLE: if (go) begin
               if (misalign) begin
                  trap  <= 1'b1;
                  state <= DONE;
               end else begin
                  dmemReq   <= 1'b1;
                  dmemWe    <= memWrite;
                  dmemAddr  <= {AluOut[ADDR_W-1:2], 2'b00};
                  dmemBe    <= be_n;
                  dmemWdata <= wdata_n;
                  wl_q      <= WL;
                  off_q     <= AluOut[1:0];
                  sext_q    <= extendSign;
                  state     <= REQ;
               end
            end
            REQ: if (dmemGnt) begin
               dmemReq <= 1'b0;
               if (dmemWe) state <= DONE;
               else if (dmemRvalid) begin
                  loadData  <= ldata;
                  loadValid <= 1'b1;
                  state     <= DONE;
               end else state <= WAIT;
            end
            WAIT: if (dmemRvalid) begin
               loadData  <= ldata;
               loadValid <= 1'b1;
               state     <= DONE;
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule
